// File: rtl/usb_pkg.sv
// usb_pkg: shared USB link constants and types.
//   PID_* : 4-bit PID codes (wire byte is {~pid, pid})
//   SYNC_BYTE, CRC16_POLY, CRC16_INIT : framing and CRC constants
//   tx_state_t : transmit control FSM states
//   bit_rev8() : byte bit reversal, used to emit CRC x^15 first
package usb_pkg;

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    localparam logic [7:0]  SYNC_BYTE  = 8'h80;
    localparam logic [15:0] CRC16_POLY = 16'h8005;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_LOAD,
        ST_DATA,
        ST_CRC_HI,
        ST_CRC_LO,
        ST_EOP_SE0,
        ST_EOP_J
    } tx_state_t;

    function automatic logic [7:0] bit_rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int unsigned i = 0; i < 8; i++) begin
            r[i] = b[7 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/usb_crc16.sv
// usb_crc16: serial CRC16 (poly 0x8005, init 0xFFFF), one bit per enabled cycle.
//   clk, n_rst : clock, asynchronous active-low reset
//   clear      : reload the initial value
//   bit_en     : absorb bit_in this cycle
//   bit_in     : data bit in wire order
//   crc_out    : running CRC register (uncomplemented, x^15 at bit 15)
module usb_crc16 (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        clear,
    input  logic        bit_en,
    input  logic        bit_in,
    output logic [15:0] crc_out
);
    import usb_pkg::*;

    logic fb;
    assign fb = bit_in ^ crc_out[15];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            crc_out <= CRC16_INIT;
        end else if (clear) begin
            crc_out <= CRC16_INIT;
        end else if (bit_en) begin
            crc_out <= {crc_out[14:0], 1'b0} ^ (fb ? CRC16_POLY : '0);
        end
    end

endmodule

// File: rtl/usb_tx_ctrl.sv
// usb_tx_ctrl: USB full-speed transmit control unit.
// Sends handshake (SYNC+PID+EOP) and data (SYNC+PID+payload+CRC16+EOP)
// packets, NRZI encoded, payload pulled from a show-ahead FIFO.
//   clk, n_rst        : clock, asynchronous active-low reset
//   tx_start, tx_pid  : send request (accepted in IDLE only) and PID code
//   tx_fifo_data/empty: FIFO head byte and empty flag; tx_fifo_rd pops
//   dplus_out/dminus_out : driven line pair (J = 1/0 at rest)
//   tx_busy, tx_done, tx_error : status
// Build option: define USB_TX_BIT_STUFF_EN to enable bit stuffing.
// CLKS_PER_BIT must be at least 2 (LOAD is evaluated one cycle before a strobe).
module usb_tx_ctrl
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned MAX_BYTES    = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [3:0] tx_pid,
    input  logic [7:0] tx_fifo_data,
    input  logic       tx_fifo_empty,
    output logic       tx_fifo_rd,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);

    localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BW = $clog2(MAX_BYTES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_PRE  = TW'(CLKS_PER_BIT - 2);

    tx_state_t       state, state_n;
    logic [TW-1:0]   tmr, tmr_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [7:0]      shreg, shreg_n;
    logic [BW-1:0]   byte_cnt, byte_cnt_n;
    logic [3:0]      pid_r, pid_n;
    logic            is_data, is_data_n;
    logic            lvl, lvl_n, lvl_base;
    logic            dp_n, dm_n, done_n, err_n;
    logic            crc_clr, crc_en;
    logic [15:0]     crc_out;
    logic            drv_en, drv_bit, new_byte;
    logic [7:0]      nb;
    logic            strobe, pre_strobe, stuff_pend;
    logic            pid_data, pid_hs, can_load;

    assign strobe     = (tmr == T_LAST);
    assign pre_strobe = (tmr == T_PRE);
    assign pid_data   = (tx_pid == PID_DATA0) || (tx_pid == PID_DATA1);
    assign pid_hs     = (tx_pid == PID_ACK) || (tx_pid == PID_NAK) || (tx_pid == PID_STALL);
    assign can_load   = !tx_fifo_empty && (byte_cnt < BW'(MAX_BYTES));
    assign tx_busy    = (state != ST_IDLE);

`ifdef USB_TX_BIT_STUFF_EN
    logic [2:0] ones, ones_n;
    assign stuff_pend = (ones == 3'd6);

    always_comb begin
        ones_n = ones;
        if (drv_en) begin
            // a new packet counts from zero regardless of the previous tail
            if (drv_bit) ones_n = ((state == ST_IDLE) ? 3'd0 : ones) + 3'd1;
            else         ones_n = '0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) ones <= '0;
        else        ones <= ones_n;
    end
`else
    assign stuff_pend = 1'b0;
`endif

    usb_crc16 u_crc (
        .clk     (clk),
        .n_rst   (n_rst),
        .clear   (crc_clr),
        .bit_en  (crc_en),
        .bit_in  (drv_bit),
        .crc_out (crc_out)
    );

    always_comb begin
        state_n    = state;
        bit_idx_n  = bit_idx;
        shreg_n    = shreg;
        byte_cnt_n = byte_cnt;
        pid_n      = pid_r;
        is_data_n  = is_data;
        lvl_n      = lvl;
        lvl_base   = lvl;
        dp_n       = dplus_out;
        dm_n       = dminus_out;
        done_n     = 1'b0;
        err_n      = 1'b0;
        tx_fifo_rd = 1'b0;
        crc_clr    = 1'b0;
        crc_en     = 1'b0;
        drv_en     = 1'b0;
        drv_bit    = 1'b0;
        new_byte   = 1'b0;
        nb         = '0;

        if (state == ST_IDLE || strobe) tmr_n = '0;
        else                            tmr_n = tmr + TW'(1);

        case (state)
            ST_IDLE: begin
                if (tx_start) begin
                    if (pid_data || pid_hs) begin
                        state_n    = ST_SYNC;
                        pid_n      = tx_pid;
                        is_data_n  = pid_data;
                        byte_cnt_n = '0;
                        crc_clr    = 1'b1;
                        lvl_base   = 1'b1;
                        new_byte   = 1'b1;
                        nb         = SYNC_BYTE;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            ST_SYNC, ST_PID, ST_DATA, ST_CRC_HI, ST_CRC_LO: begin
                if (strobe) begin
                    if (stuff_pend) begin
                        // stuffed 0: no bit index or CRC advance
                        drv_en  = 1'b1;
                        drv_bit = 1'b0;
                    end else if (bit_idx != 3'd7) begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[7:1]};
                        drv_en    = 1'b1;
                        drv_bit   = shreg[1];
                        crc_en    = (state == ST_DATA);
                    end else begin
                        case (state)
                            ST_SYNC: begin
                                state_n  = ST_PID;
                                new_byte = 1'b1;
                                nb       = {~pid_r, pid_r};
                            end
                            ST_CRC_HI: begin
                                state_n  = ST_CRC_LO;
                                new_byte = 1'b1;
                                nb       = bit_rev8(~crc_out[7:0]);
                            end
                            default: begin
                                state_n   = ST_EOP_SE0;
                                bit_idx_n = '0;
                                dp_n      = 1'b0;
                                dm_n      = 1'b0;
                            end
                        endcase
                    end
                end else if (pre_strobe && bit_idx == 3'd7 && !stuff_pend &&
                             (state == ST_DATA || (state == ST_PID && is_data))) begin
                    // byte boundary decided during the last cycle of the final bit
                    state_n = ST_LOAD;
                end
            end

            // always occupies exactly the strobe cycle of the previous byte's last bit
            ST_LOAD: begin
                if (can_load) begin
                    tx_fifo_rd = 1'b1;
                    state_n    = ST_DATA;
                    byte_cnt_n = byte_cnt + BW'(1);
                    new_byte   = 1'b1;
                    nb         = tx_fifo_data;
                    crc_en     = 1'b1;
                end else begin
                    state_n  = ST_CRC_HI;
                    new_byte = 1'b1;
                    nb       = bit_rev8(~crc_out[15:8]);
                end
            end

            ST_EOP_SE0: begin
                if (strobe) begin
                    if (bit_idx == 3'd1) begin
                        state_n   = ST_EOP_J;
                        bit_idx_n = '0;
                        dp_n      = 1'b1;
                        dm_n      = 1'b0;
                    end else begin
                        bit_idx_n = 3'd1;
                    end
                end
            end

            ST_EOP_J: begin
                if (strobe) begin
                    state_n = ST_IDLE;
                    done_n  = 1'b1;
                end
            end

            default: state_n = ST_IDLE;
        endcase

        if (new_byte) begin
            shreg_n   = nb;
            bit_idx_n = '0;
            drv_en    = 1'b1;
            drv_bit   = nb[0];
        end

        if (drv_en) begin
            lvl_n = drv_bit ? lvl_base : ~lvl_base;
            dp_n  = lvl_n;
            dm_n  = ~lvl_n;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state      <= ST_IDLE;
            tmr        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_cnt   <= '0;
            pid_r      <= '0;
            is_data    <= 1'b0;
            lvl        <= 1'b1;
            dplus_out  <= 1'b1;
            dminus_out <= 1'b0;
            tx_done    <= 1'b0;
            tx_error   <= 1'b0;
        end else begin
            state      <= state_n;
            tmr        <= tmr_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            byte_cnt   <= byte_cnt_n;
            pid_r      <= pid_n;
            is_data    <= is_data_n;
            lvl        <= lvl_n;
            dplus_out  <= dp_n;
            dminus_out <= dm_n;
            tx_done    <= done_n;
            tx_error   <= err_n;
        end
    end

endmodule

// File: tb/tb_usb_tx_ctrl.sv
// tb_usb_tx_ctrl: directed bench for usb_tx_ctrl (CLKS_PER_BIT=4, MAX_BYTES=64).
// Line samples are compared against a bench-built expected waveform
// (reflected CRC-16/USB reference, optional stuffing, NRZI from J).
module tb_usb_tx_ctrl;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       tx_start;
    logic [3:0] tx_pid;
    logic [7:0] tx_fifo_data;
    logic       tx_fifo_empty;
    logic       tx_fifo_rd;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int vectors     = 0;
    int miscompares = 0;

    usb_tx_ctrl #(.CLKS_PER_BIT(4), .MAX_BYTES(64)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .tx_start      (tx_start),
        .tx_pid        (tx_pid),
        .tx_fifo_data  (tx_fifo_data),
        .tx_fifo_empty (tx_fifo_empty),
        .tx_fifo_rd    (tx_fifo_rd),
        .dplus_out     (dplus_out),
        .dminus_out    (dminus_out),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_error      (tx_error)
    );

    always #5 clk = ~clk;

    // show-ahead FIFO model
    logic [7:0] mem [0:255];
    int wr_cnt = 0;
    int skip   = 0;
    int rd_ptr = 0;

    always @(posedge clk) begin
        if (tx_fifo_rd) rd_ptr <= rd_ptr + 1;
    end

    assign tx_fifo_empty = (rd_ptr + skip) >= wr_cnt;
    assign tx_fifo_data  = mem[8'(rd_ptr + skip)];

    logic [1:0] cap  [0:3999];
    logic [1:0] expw [0:3999];
    int exp_done;
    bit raw[$];
    bit wire_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push_fifo(input logic [7:0] b);
        mem[8'(wr_cnt)] = b;
        wr_cnt++;
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) raw.push_back(b[i]);
    endtask

    task automatic build_exp(input logic [3:0] pid, input int first, input int n);
        logic [15:0] r;
        bit lv;
        int k;
`ifdef USB_TX_BIT_STUFF_EN
        int ones;
        ones = 0;
`endif
        raw.delete();
        wire_q.delete();
        push_byte(8'h80);
        push_byte({~pid, pid});
        if (pid == 4'b0011 || pid == 4'b1011) begin
            r = 16'hFFFF;
            for (int i = 0; i < n; i++) begin
                push_byte(mem[8'(first + i)]);
                r = r ^ {8'h00, mem[8'(first + i)]};
                for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
            end
            r = ~r;
            push_byte(r[7:0]);
            push_byte(r[15:8]);
        end
        foreach (raw[i]) begin
            wire_q.push_back(raw[i]);
`ifdef USB_TX_BIT_STUFF_EN
            ones = raw[i] ? ones + 1 : 0;
            if (ones == 6) begin
                wire_q.push_back(1'b0);
                ones = 0;
            end
`endif
        end
        lv = 1'b1;
        k  = 1;
        foreach (wire_q[i]) begin
            if (!wire_q[i]) lv = ~lv;
            for (int j = 0; j < 4; j++) begin
                expw[k] = {lv, ~lv};
                k++;
            end
        end
        for (int j = 0; j < 8; j++) begin expw[k] = 2'b00; k++; end
        for (int j = 0; j < 4; j++) begin expw[k] = 2'b10; k++; end
        exp_done = k;
    endtask

    // Starts a packet and records lines until tx_done (bounded).
    task automatic run_pkt(input logic [3:0] pid, input int poke,
                           output int done_at, output int busy_bad, output int pops);
        int c;
        int rp0;
        done_at  = -1;
        busy_bad = 0;
        for (int i = 0; i < 4000; i++) cap[i] = 2'bxx;
        @(negedge clk);
        tx_pid   = pid;
        tx_start = 1'b1;
        rp0      = rd_ptr;
        @(negedge clk);
        tx_start = 1'b0;
        c = 1;
        while (c < 3999) begin
            cap[c] = {dplus_out, dminus_out};
            if (tx_done) begin
                done_at = c;
                break;
            end
            if (!tx_busy) busy_bad++;
            if (c == poke) begin
                tx_start = 1'b1;
                tx_pid   = 4'b1011;
            end else begin
                tx_start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        tx_start = 1'b0;
        pops = rd_ptr - rp0;
    endtask

    task automatic check_pkt(input string tag, input int done_at, input int busy_bad,
                             input int pops, input int exp_pops);
        int mism;
        mism = 0;
        for (int c = 1; c < exp_done; c++) begin
            if (cap[c] !== expw[c]) mism++;
        end
        chk({tag, " wave"}, mism, 0);
        chk({tag, " done_cycle"}, done_at, exp_done);
        chk({tag, " busy"}, busy_bad, 0);
        chk({tag, " pops"}, pops, exp_pops);
        @(negedge clk);
        chk({tag, " done_pulse"}, tx_done, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int d, bb, p, first, rp;
        bit saw_done;

        n_rst    = 1'b0;
        tx_start = 1'b0;
        tx_pid   = 4'b0000;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;

        repeat (3) @(negedge clk);
        chk("rst dplus", dplus_out, 1'b1);
        chk("rst dminus", dminus_out, 1'b0);
        chk("rst busy", tx_busy, 1'b0);
        chk("rst done", tx_done, 1'b0);
        chk("rst rd", tx_fifo_rd, 1'b0);
        chk("rst err", tx_error, 1'b0);
        n_rst = 1'b1;
        repeat (2) @(negedge clk);

        // ACK with a tx_start poked while busy
        build_exp(4'b0010, 0, 0);
        run_pkt(4'b0010, 20, d, bb, p);
        chk("ack first_bit_K", cap[1], 2'b01);
        chk("ack done_literal", d, 77);
        check_pkt("ack", d, bb, p, 0);

        // DATA0, empty FIFO
        build_exp(4'b0011, 0, 0);
        run_pkt(4'b0011, 0, d, bb, p);
        chk("d0_empty done_literal", d, 141);
        check_pkt("d0_empty", d, bb, p, 0);

        // DATA1, 70 queued bytes: only 64 sent
        first = wr_cnt;
        for (int i = 0; i < 70; i++) push_fifo(8'((i * 37 + 5) ^ (i >> 2)));
        build_exp(4'b1011, first, 64);
        run_pkt(4'b1011, 0, d, bb, p);
        check_pkt("d1_70", d, bb, p, 64);
        chk("d1_70 leftover", wr_cnt - (rd_ptr + skip), 6);
        skip = wr_cnt - rd_ptr;

        // DATA0, single 0xFF payload
        first = wr_cnt;
        push_fifo(8'hFF);
        build_exp(4'b0011, first, 1);
        run_pkt(4'b0011, 0, d, bb, p);
`ifdef USB_TX_BIT_STUFF_EN
        chk("d0_ff done_literal", d, 181);
`else
        chk("d0_ff done_literal", d, 173);
`endif
        check_pkt("d0_ff", d, bb, p, 1);

        // unsupported PID
        @(negedge clk);
        tx_pid   = 4'b0001;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        chk("badpid err", tx_error, 1'b1);
        chk("badpid busy", tx_busy, 1'b0);
        chk("badpid line", {dplus_out, dminus_out}, 2'b10);
        @(negedge clk);
        chk("badpid err_pulse", tx_error, 1'b0);
        repeat (8) @(negedge clk);
        chk("badpid line_later", {dplus_out, dminus_out, tx_busy}, 3'b100);

        // reset during DATA
        first = wr_cnt;
        for (int i = 0; i < 10; i++) push_fifo(8'(8'hA5 + i));
        @(negedge clk);
        tx_pid   = 4'b0011;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (100) @(negedge clk);
        chk("midrst in_data", tx_busy, 1'b1);
        @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        chk("midrst line", {dplus_out, dminus_out}, 2'b10);
        chk("midrst busy", tx_busy, 1'b0);
        rp = rd_ptr;
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tx_done) saw_done = 1'b1;
        end
        n_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tx_done) saw_done = 1'b1;
        end
        chk("midrst no_done", saw_done, 1'b0);
        chk("midrst no_pop", rd_ptr, rp);
        skip = wr_cnt - rd_ptr;

        // normal packet after reset
        build_exp(4'b1010, 0, 0);
        run_pkt(4'b1010, 0, d, bb, p);
        check_pkt("nak_after_rst", d, bb, p, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
